// File: rtl/carga_contador_irrigacao.sv
// Load-side controller for the irrigation countdown counter: latches a clamped setpoint,
// strobes the counter load, holds the valve open until Q hits the terminal value.
module carga_contador_irrigacao #(
  parameter int WIDTH      = 4,
  parameter int TERM       = 0,
  parameter int MAX_PRESET = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             umido,
  input  logic [WIDTH-1:0] setpoint_in,
  input  logic [WIDTH-1:0] q_cnt,
  output logic [WIDTH-1:0] preset,
  output logic             botao,
  output logic             valvula,
  output logic             busy,
  output logic             done,
  output logic             erro
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERRO   = 3'd5;

  localparam int             TW     = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] W_TERM = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] W_MAX  = WIDTH'(MAX_PRESET);
  localparam logic [TW-1:0]    W_TMAX = TW'(TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_start_d;
  logic [TW-1:0]    r_tcnt;
  logic             w_start_ev;
  logic [WIDTH-1:0] w_sp;

  assign w_start_ev = start & ~r_start_d;
  assign w_sp       = (setpoint_in > W_MAX) ? W_MAX : setpoint_in;

  // In LOAD the preset register already holds the latched setpoint.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ev && !umido) w_next = S_LOAD;
      S_LOAD:   w_next = (preset == W_TERM) ? S_DONE : S_SETTLE;
      S_SETTLE: w_next = S_RUN;
      S_RUN: begin
        if (q_cnt == W_TERM)      w_next = S_DONE;
        else if (umido)           w_next = S_DONE;
        else if (r_tcnt == W_TMAX) w_next = S_ERRO;
      end
      S_DONE:   w_next = S_IDLE;
      S_ERRO:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
      r_tcnt    <= '0;
      preset    <= '0;
      botao     <= 1'b0;
      valvula   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      erro      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_d <= start;
      botao     <= (w_next == S_LOAD);
      valvula   <= (w_next == S_RUN);
      done      <= (w_next == S_DONE);
      busy      <= (w_next != S_IDLE);
      if (r_state == S_IDLE && w_next == S_LOAD) begin
        preset <= w_sp;
        erro   <= 1'b0;
        r_tcnt <= '0;
      end else if (w_next == S_ERRO) begin
        erro <= 1'b1;
      end
      if (r_state == S_RUN && w_next == S_RUN && r_tcnt != W_TMAX)
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_carga_contador_irrigacao.sv
// Scoreboard bench: a behavioural countdown counter in the loop, expected load/end records
// queued at stimulus time and checked by an independent monitor.
module tb_carga_contador_irrigacao;

  localparam int WIDTH = 4;
  localparam int TERM  = 0;
  localparam int MAXP  = 4;
  localparam int TMO   = 31;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             umido = 1'b0;
  logic [WIDTH-1:0] setpoint_in = '0;
  logic [WIDTH-1:0] q_cnt;
  logic [WIDTH-1:0] preset;
  logic             botao, valvula, busy, done, erro;
  logic             stuck = 1'b0;

  always #5 clock = ~clock;

  carga_contador_irrigacao #(
    .WIDTH(WIDTH), .TERM(TERM), .MAX_PRESET(MAXP), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .umido(umido),
    .setpoint_in(setpoint_in), .q_cnt(q_cnt), .preset(preset), .botao(botao),
    .valvula(valvula), .busy(busy), .done(done), .erro(erro)
  );

  // Countdown counter being controlled: loads on botao, counts down to zero unless stuck.
  always @(posedge clock or negedge resetn) begin
    if (!resetn)                  q_cnt <= '0;
    else if (botao)               q_cnt <= preset;
    else if (!stuck && q_cnt != 0) q_cnt <= q_cnt - 1'b1;
  end

  typedef struct {
    int unsigned pre;
    bit          is_err;
    int unsigned vc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ends_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: mode 0 normal countdown, 1 soil turns wet in RUN cycle k, 2 counter stuck.
  function automatic exp_t model(input int unsigned sp_in, input int mode, input int unsigned k);
    exp_t e;
    int unsigned sp;
    sp = (sp_in > MAXP) ? MAXP : sp_in;
    e.pre = sp;
    e.is_err = 1'b0;
    if (sp == TERM)     e.vc = 0;
    else if (mode == 1) e.vc = (k < sp) ? k : sp;
    else if (mode == 2) begin e.vc = TMO + 1; e.is_err = 1'b1; end
    else                e.vc = sp;
    return e;
  endfunction

  bit          in_txn = 1'b0;
  exp_t        cur;
  int unsigned vcnt = 0;
  logic        botao_p = 1'b0;
  logic        erro_p = 1'b0;

  always @(negedge clock) begin
    if (!resetn) begin
      in_txn  = 1'b0;
      vcnt    = 0;
      botao_p = 1'b0;
      erro_p  = 1'b0;
    end else begin
      if (botao) begin
        chk("botao_width", {31'd0, botao_p}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_botao: preset=%0d while no load was expected", preset);
        end else begin
          cur = exp_q.pop_front();
          chk("preset", {28'd0, preset}, cur.pre);
          chk("erro_clear_on_load", {31'd0, erro}, 0);
          chk("busy_on_load", {31'd0, busy}, 1);
          in_txn = 1'b1;
          vcnt   = 0;
        end
      end
      if (valvula) vcnt++;
      if (done || (erro && !erro_p)) begin
        if (!in_txn) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: done=%0d erro=%0d with no cycle in progress", done, erro);
        end else begin
          chk("end_is_erro", {31'd0, erro && !erro_p}, {31'd0, cur.is_err});
          chk("end_done", {31'd0, done}, {31'd0, !cur.is_err});
          chk("valve_cycles", vcnt, cur.vc);
          in_txn = 1'b0;
          ends_seen++;
        end
      end
      botao_p = botao;
      erro_p  = erro;
    end
  end

  task automatic run_txn(input int unsigned sp_in, input int mode, input int unsigned k,
                         input bit hold);
    exp_t e;
    int   base;
    bit   got;
    e = model(sp_in, mode, k);
    @(negedge clock);
    setpoint_in = WIDTH'(sp_in);
    stuck = (mode == 2);
    umido = 1'b0;
    start = 1'b1;
    exp_q.push_back(e);
    base = ends_seen;
    got = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clock);
      if (j == 1 && !hold) start = 1'b0;
      if (hold && j == 10) start = 1'b0;
      if (mode == 1 && j == int'(k) + 2) umido = 1'b1;
      if (ends_seen != base && (!hold || j >= 10)) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL cycle_timeout: no end within 200 cycles for setpoint %0d", sp_in);
      exp_q.delete();
    end
    @(negedge clock);
    umido = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_valvula", {31'd0, valvula}, 0);
    chk("erro_after_cycle", {31'd0, erro}, {31'd0, e.is_err});
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_preset", {28'd0, preset}, 0);
    chk("rst_botao", {31'd0, botao}, 0);
    chk("rst_valvula", {31'd0, valvula}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_erro", {31'd0, erro}, 0);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clock);

    run_txn(3, 0, 0, 1'b0);
    run_txn(9, 0, 0, 1'b0);
    run_txn(0, 0, 0, 1'b0);
    run_txn(4, 1, 2, 1'b0);

    // Start while the soil is already wet must not load the counter.
    @(negedge clock);
    umido = 1'b1;
    setpoint_in = 4'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("wet_start_busy", {31'd0, busy}, 0);
    umido = 1'b0;

    run_txn(3, 2, 0, 1'b0);
    run_txn(2, 0, 0, 1'b1);

    // Reset in the middle of RUN.
    @(negedge clock);
    setpoint_in = 4'd4;
    exp_q.push_back(model(4, 0, 0));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_reset_valvula", {31'd0, valvula}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_valvula", {31'd0, valvula}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_preset", {28'd0, preset}, 0);
    chk("async_done", {31'd0, done}, 0);
    exp_q.delete();
    @(negedge clock);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_reset_busy", {31'd0, busy}, 0);
    chk("post_reset_done", {31'd0, done}, 0);
    run_txn(1, 0, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      run_txn($urandom_range(0, 15), int'($urandom_range(0, 2)), $urandom_range(1, 6), 1'b0);
    end

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
